// File: rtl/pong_referee_if.sv
// Pong referee bus: frame/start controls, ball and paddle geometry in,
// bounce event, scores and match status out.
// master: position/size source (drives geometry, frame_tick, start)
// slave : referee (drives bounce, bounce_valid, scores, status)
interface pong_referee_if #(
    parameter int POS_W   = 10,
    parameter int SIZE_W  = 8,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic [POS_W-1:0]   ball_pos_x;
    logic [POS_W-1:0]   ball_pos_y;
    logic [SIZE_W-1:0]  ball_size_x;
    logic [SIZE_W-1:0]  ball_size_y;
    logic [POS_W-1:0]   paddle_1_pos_x;
    logic [POS_W-1:0]   paddle_1_pos_y;
    logic [SIZE_W-1:0]  paddle_1_size_x;
    logic [SIZE_W-1:0]  paddle_1_size_y;
    logic [POS_W-1:0]   paddle_2_pos_x;
    logic [POS_W-1:0]   paddle_2_pos_y;
    logic [SIZE_W-1:0]  paddle_2_size_x;
    logic [SIZE_W-1:0]  paddle_2_size_y;
    logic [1:0]         bounce;
    logic               bounce_valid;
    logic [SCORE_W-1:0] score_player_1;
    logic [SCORE_W-1:0] score_player_2;
    logic               serve_active;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output frame_tick, start,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        output paddle_1_pos_x, paddle_1_pos_y,
        output paddle_1_size_x, paddle_1_size_y,
        output paddle_2_pos_x, paddle_2_pos_y,
        output paddle_2_size_x, paddle_2_size_y,
        input  bounce, bounce_valid,
        input  score_player_1, score_player_2,
        input  serve_active, game_over, winner
    );

    modport slave (
        input  frame_tick, start,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        input  paddle_1_pos_x, paddle_1_pos_y,
        input  paddle_1_size_x, paddle_1_size_y,
        input  paddle_2_pos_x, paddle_2_pos_y,
        input  paddle_2_size_x, paddle_2_size_y,
        output bounce, bounce_valid,
        output score_player_1, score_player_2,
        output serve_active, game_over, winner
    );
endinterface

// File: rtl/pong_referee.sv
// Pong referee: per-frame collision check, debounced bounce events,
// scoring, timed serve and match FSM (IDLE/SERVE/PLAY/OVER).
// clock, reset (async active-high); bus: pong_referee_if.slave
//   in : frame_tick, start, ball/paddle positions and sizes
//   out: bounce, bounce_valid, scores, serve_active, game_over, winner
module pong_referee #(
    parameter int SCREEN_X     = 640,
    parameter int SCREEN_Y     = 480,
    parameter int MARGIN       = 5,
    parameter int POS_W        = 10,
    parameter int SIZE_W       = 8,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input logic           clock,
    input logic           reset,
    pong_referee_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_SERVE, S_PLAY, S_OVER
    } state_t;

    localparam int EW    = POS_W + 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [EW-1:0] C_MARGIN = EW'(MARGIN);
    localparam logic [EW-1:0] C_RGOAL  = EW'(SCREEN_X - MARGIN);
    localparam logic [EW-1:0] C_FLOOR  = EW'(SCREEN_Y - MARGIN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] C_WIN = SCORE_W'(WIN_SCORE);

    // Inclusive far edge, one bit wider so pos+size never wraps.
    function automatic logic [EW-1:0] edge_far(
        input logic [POS_W-1:0]  p,
        input logic [SIZE_W-1:0] s
    );
        return {1'b0, p} + EW'(s);
    endfunction

    function automatic logic overlap(
        input logic [EW-1:0] a0, a1, b0, b1
    );
        return (a0 <= b1) && (b0 <= a1);
    endfunction

    state_t             r_state, w_state;
    logic [SCORE_W-1:0] r_score1, w_score1;
    logic [SCORE_W-1:0] r_score2, w_score2;
    logic [1:0]         r_bounce, w_bounce;
    logic               r_valid, w_valid;
    logic [1:0]         r_winner, w_winner;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_wall_latch, w_wall_latch;
    logic               r_pad_latch, w_pad_latch;

    logic [EW-1:0] w_bx0, w_bx1, w_by0, w_by1;
    logic          w_rgoal, w_lgoal, w_wall, w_pad;
    logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;

    assign w_bx0 = {1'b0, bus.ball_pos_x};
    assign w_by0 = {1'b0, bus.ball_pos_y};
    assign w_bx1 = edge_far(bus.ball_pos_x, bus.ball_size_x);
    assign w_by1 = edge_far(bus.ball_pos_y, bus.ball_size_y);

    assign w_rgoal = w_bx1 >= C_RGOAL;
    assign w_lgoal = w_bx0 <= C_MARGIN;
    assign w_wall  = (w_by1 >= C_FLOOR) || (w_by0 <= C_MARGIN);

    assign w_pad =
        (overlap(w_bx0, w_bx1, {1'b0, bus.paddle_1_pos_x},
                 edge_far(bus.paddle_1_pos_x, bus.paddle_1_size_x)) &&
         overlap(w_by0, w_by1, {1'b0, bus.paddle_1_pos_y},
                 edge_far(bus.paddle_1_pos_y, bus.paddle_1_size_y))) ||
        (overlap(w_bx0, w_bx1, {1'b0, bus.paddle_2_pos_x},
                 edge_far(bus.paddle_2_pos_x, bus.paddle_2_size_x)) &&
         overlap(w_by0, w_by1, {1'b0, bus.paddle_2_pos_y},
                 edge_far(bus.paddle_2_pos_y, bus.paddle_2_size_y)));

    assign w_s1_inc = r_score1 + 1'b1;
    assign w_s2_inc = r_score2 + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_score1     <= '0;
            r_score2     <= '0;
            r_bounce     <= 2'b00;
            r_valid      <= 1'b0;
            r_winner     <= 2'b00;
            r_cnt        <= '0;
            r_wall_latch <= 1'b0;
            r_pad_latch  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_score1     <= w_score1;
            r_score2     <= w_score2;
            r_bounce     <= w_bounce;
            r_valid      <= w_valid;
            r_winner     <= w_winner;
            r_cnt        <= w_cnt;
            r_wall_latch <= w_wall_latch;
            r_pad_latch  <= w_pad_latch;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_score1     = r_score1;
        w_score2     = r_score2;
        w_bounce     = r_bounce;
        w_valid      = 1'b0;
        w_winner     = r_winner;
        w_cnt        = r_cnt;
        w_wall_latch = r_wall_latch;
        w_pad_latch  = r_pad_latch;
        case (r_state)
            S_IDLE, S_OVER: begin
                // start also masks any coincident frame_tick
                if (bus.start) begin
                    w_state      = S_SERVE;
                    w_score1     = '0;
                    w_score2     = '0;
                    w_winner     = 2'b00;
                    w_cnt        = '0;
                    w_wall_latch = 1'b0;
                    w_pad_latch  = 1'b0;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_cnt == C_LAST) begin
                        w_state = S_PLAY;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (w_rgoal || w_lgoal) begin
                        w_bounce     = 2'b11;
                        w_valid      = 1'b1;
                        w_wall_latch = 1'b0;
                        w_pad_latch  = 1'b0;
                        w_cnt        = '0;
                        w_state      = S_SERVE;
                        if (w_rgoal) begin
                            w_score1 = w_s1_inc;
                            if (w_s1_inc == C_WIN) begin
                                w_state  = S_OVER;
                                w_winner = 2'b01;
                            end
                        end else begin
                            w_score2 = w_s2_inc;
                            if (w_s2_inc == C_WIN) begin
                                w_state  = S_OVER;
                                w_winner = 2'b10;
                            end
                        end
                    end else begin
                        // Latches release on the first frame without
                        // that kind of contact.
                        w_wall_latch = w_wall;
                        w_pad_latch  = w_pad;
                        if (w_wall) begin
                            w_pad_latch = r_pad_latch && w_pad;
                            if (!r_wall_latch) begin
                                w_bounce = 2'b10;
                                w_valid  = 1'b1;
                            end
                        end else if (w_pad && !r_pad_latch) begin
                            w_bounce = 2'b01;
                            w_valid  = 1'b1;
                        end
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.bounce         = r_bounce;
    assign bus.bounce_valid   = r_valid;
    assign bus.score_player_1 = r_score1;
    assign bus.score_player_2 = r_score2;
    assign bus.winner         = r_winner;
    assign bus.serve_active   = (r_state == S_SERVE);
    assign bus.game_over      = (r_state == S_OVER);
endmodule
